// File: rtl/wallace_final_adder.sv
// Final carry-propagate adder for the pipelined Wallace-tree multiplier.
// Two-stage split adder (low half, then high half plus carry) with valid/ready flow control.
module wallace_final_adder #(
   parameter int ROW_W = 65,
   parameter int P_W   = 64,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ROW_W-1:0] in_sum,
   input  logic [ROW_W-1:0] in_carry,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [P_W-1:0]   out_product,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_ovf,
   output logic [7:0]       err_count
);

   localparam int HALF = P_W / 2;
   localparam int HI_W = ROW_W - HALF;

   logic            a_valid;
   logic [HALF-1:0] a_lo;
   logic            a_c32;
   logic [HI_W-1:0] a_sum_hi;
   logic [HI_W-1:0] a_carry_hi;
   logic [TAG_W-1:0] a_tag;

   logic            a_load;
   logic            b_load;
   logic            out_xfer;
   logic [HALF:0]   lo;
   logic [HI_W:0]   hi;

   // Stage A may accept whenever it will be empty after this edge; never while in reset.
   assign in_ready = rst & (!a_valid | !out_valid | out_ready);
   assign a_load   = in_valid & in_ready;
   assign b_load   = a_valid & (!out_valid | out_ready);
   assign out_xfer = out_valid & out_ready;

   assign lo = {1'b0, in_sum[HALF-1:0]} + {1'b0, in_carry[HALF-1:0]};
   assign hi = {1'b0, a_sum_hi} + {1'b0, a_carry_hi} + {{HI_W{1'b0}}, a_c32};

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_valid    <= 1'b0;
         a_lo       <= '0;
         a_c32      <= 1'b0;
         a_sum_hi   <= '0;
         a_carry_hi <= '0;
         a_tag      <= '0;
      end else begin
         if (a_load) begin
            a_valid    <= 1'b1;
            a_lo       <= lo[HALF-1:0];
            a_c32      <= lo[HALF];
            a_sum_hi   <= in_sum[ROW_W-1:HALF];
            a_carry_hi <= in_carry[ROW_W-1:HALF];
            a_tag      <= in_tag;
         end else if (b_load) begin
            a_valid <= 1'b0;
         end
      end
   end

   // Any bit of the high-half sum above the product width marks an overflowing row.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid   <= 1'b0;
         out_product <= '0;
         out_tag     <= '0;
         out_ovf     <= 1'b0;
      end else begin
         if (b_load) begin
            out_valid   <= 1'b1;
            out_product <= {hi[P_W-HALF-1:0], a_lo};
            out_tag     <= a_tag;
            out_ovf     <= |hi[HI_W:P_W-HALF];
         end else if (out_xfer) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         err_count <= '0;
      end else if (out_xfer && out_ovf && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_wallace_final_adder.sv
// Directed bench for wallace_final_adder: vector table, streaming, backpressure,
// reset mid-flight and error-counter saturation, with a scoreboard of hand-computed results.
module tb_wallace_final_adder;

   typedef struct {
      logic [64:0] sum;
      logic [64:0] carry;
      logic [3:0]  tag;
      logic [63:0] prod;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [63:0] prod;
      logic [3:0]  tag;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [64:0] in_sum;
   logic [64:0] in_carry;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_product;
   logic [3:0]  out_tag;
   logic        out_ovf;
   logic [7:0]  err_count;

   int   vectors_applied = 0;
   int   miscompares = 0;
   int   ov_cycles;
   vec_t vecs [9];
   vec_t cur;
   vec_t tmp;
   exp_t sb [$];

   wallace_final_adder dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sum      (in_sum),
      .in_carry    (in_carry),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .out_tag     (out_tag),
      .out_ovf     (out_ovf),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors_applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      cur      = v;
      in_valid = 1'b1;
      in_sum   = v.sum;
      in_carry = v.carry;
      in_tag   = v.tag;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // Scores transfers about to happen at the coming edge, then advances to 1ns past it.
   task automatic step();
      exp_t e;
      #1;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL unexpected_output: got tag 0x%0h product 0x%0h, expected none",
                     out_tag, out_product);
         end else begin
            e = sb.pop_front();
            checkOutput("sb_product", out_product, e.prod);
            checkOutput("sb_tag", 64'(out_tag), 64'(e.tag));
            checkOutput("sb_ovf", 64'(out_ovf), 64'(e.ovf));
         end
      end
      if (in_valid && in_ready) begin
         e.prod = cur.prod;
         e.tag  = cur.tag;
         e.ovf  = cur.ovf;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      for (int k = 0; k < 20 && sb.size() > 0; k++) step();
      checkOutput("drain_left", 64'(sb.size()), 64'd0);
      checkOutput("drain_out_valid", 64'(out_valid), 64'd0);
   endtask

   task automatic sendSingle(input int idx);
      applyStimulus(vecs[idx]);
      step();
      idle();
      checkOutput("single_not_early", 64'(out_valid), 64'd0);
      step();
      checkOutput("single_valid", 64'(out_valid), 64'd1);
      checkOutput("single_product", out_product, vecs[idx].prod);
      step();
      checkOutput("single_gone", 64'(out_valid), 64'd0);
   endtask

   initial begin
      vecs[0] = '{65'h0_00000000_FFFFFFFF, 65'h0_00000000_00000001, 4'h3, 64'h00000001_00000000, 1'b0};
      vecs[1] = '{65'h0_FFFFFFFE_00000000, 65'h0_00000000_00000001, 4'h5, 64'hFFFFFFFE_00000001, 1'b0};
      vecs[2] = '{65'h0_FFFFFFFF_FFFFFFFF, 65'h0_00000000_00000001, 4'h6, 64'h00000000_00000000, 1'b1};
      vecs[3] = '{65'h1_00000000_00000000, 65'h0_00000000_00000000, 4'h7, 64'h00000000_00000000, 1'b1};
      vecs[4] = '{65'h0_12345678_9ABCDEF0, 65'h0_11111111_11111111, 4'h8, 64'h23456789_ABCDF001, 1'b0};
      vecs[5] = '{65'h0_80000000_80000000, 65'h0_80000000_80000000, 4'h9, 64'h00000001_00000000, 1'b1};
      vecs[6] = '{65'h1_FFFFFFFF_FFFFFFFF, 65'h1_FFFFFFFF_FFFFFFFF, 4'hF, 64'hFFFFFFFF_FFFFFFFE, 1'b1};
      vecs[7] = '{65'h0_00000000_00000000, 65'h0_00000000_00000000, 4'h0, 64'h00000000_00000000, 1'b0};
      vecs[8] = '{65'h0_00000001_00000000, 65'h0_FFFFFFFF_00000000, 4'h1, 64'h00000000_00000000, 1'b1};

      rst = 1'b0;
      in_valid = 1'b0;
      in_sum = '0;
      in_carry = '0;
      in_tag = '0;
      out_ready = 1'b0;
      cur = vecs[7];

      @(posedge clk);
      #1;
      step();
      checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_err_count", 64'(err_count), 64'd0);
      checkOutput("reset_product", out_product, 64'd0);
      rst = 1'b1;
      #1;
      checkOutput("release_in_ready", 64'(in_ready), 64'd1);
      checkOutput("release_out_valid", 64'(out_valid), 64'd0);

      // Latency, carry across halves, and first overflow.
      out_ready = 1'b1;
      sendSingle(0);
      sendSingle(1);
      checkOutput("err_before_ovf", 64'(err_count), 64'd0);
      sendSingle(2);
      checkOutput("err_after_ovf", 64'(err_count), 64'd1);

      // Whole table back to back.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput("table_in_ready", 64'(in_ready), 64'd1);
         step();
      end
      drain();
      checkOutput("table_err_count", 64'(err_count), 64'd6);

      // Sixteen-op stream with tags 0..15.
      ov_cycles = 0;
      for (int i = 0; i < 16; i++) begin
         logic [31:0] v;
         v = 32'(i);
         tmp = '{{1'b0, v, v}, {1'b0, v, v}, 4'(i), {v << 1, v << 1}, 1'b0};
         applyStimulus(tmp);
         #1;
         checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
         step();
         if (out_valid) ov_cycles++;
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         step();
         if (out_valid) ov_cycles++;
      end
      checkOutput("stream_valid_cycles", 64'(ov_cycles), 64'd16);
      checkOutput("stream_left", 64'(sb.size()), 64'd0);

      // Backpressure: two ops fill the pipe, third waits.
      out_ready = 1'b0;
      applyStimulus(vecs[3]);
      step();
      applyStimulus(vecs[4]);
      #1;
      checkOutput("bp_second_ready", 64'(in_ready), 64'd1);
      step();
      applyStimulus(vecs[5]);
      #1;
      checkOutput("bp_full_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_product", out_product, vecs[3].prod);
      step();
      step();
      checkOutput("bp_hold_product", out_product, vecs[3].prod);
      checkOutput("bp_hold_tag", 64'(out_tag), 64'(vecs[3].tag));
      checkOutput("bp_hold_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
      step();
      idle();
      out_ready = 1'b0;
      checkOutput("bp_next_tag", 64'(out_tag), 64'(vecs[4].tag));
      step();
      checkOutput("bp_next_hold", out_product, vecs[4].prod);
      out_ready = 1'b1;
      drain();
      checkOutput("bp_err_count", 64'(err_count), 64'd8);

      // Reset with two ops in flight.
      out_ready = 1'b0;
      applyStimulus(vecs[6]);
      step();
      applyStimulus(vecs[1]);
      step();
      idle();
      rst = 1'b0;
      step();
      sb.delete();
      checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst_err_count", 64'(err_count), 64'd0);
      checkOutput("midrst_product", out_product, 64'd0);
      checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("postrst_no_output", 64'(out_valid), 64'd0);
      end

      // Error-counter saturation.
      for (int i = 0; i < 260; i++) begin
         logic [31:0] v;
         v = 32'(i);
         tmp = '{{1'b1, 32'h0, v}, 65'h0, 4'(i), {32'h0, v}, 1'b1};
         applyStimulus(tmp);
         step();
         if (i == 254) begin
            drain();
            checkOutput("sat_reach_255", 64'(err_count), 64'd255);
         end
      end
      drain();
      checkOutput("sat_hold_255", 64'(err_count), 64'd255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule

// File: doc/wallace_final_adder.md
# wallace_final_adder

Terminal consumer of the pipelined Wallace-tree multiplier. It accepts the two reduced 65-bit rows (sum and carry) produced by the last tree-level register and resolves them into the 64-bit product. Resolution runs through a two-stage pipelined carry-propagate adder with valid/ready flow control. It also flags rows whose resolved value does not fit in 64 bits and keeps a saturating count of such errors.

## Interface
- ROW_W, 65, width of each incoming reduced row
- P_W, 64, product width
- TAG_W, 4, width of sideband tag carried alongside each operation
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  in_sum/in_carry/in_tag valid this cycle
- in_ready  output  1  block accepts input this cycle
- in_sum  input  ROW_W  reduced sum row
- in_carry  input  ROW_W  reduced carry row, already weight-aligned (no further shift)
- in_tag  input  TAG_W  opaque sideband, returned unchanged with result
- out_valid  output  1  out_product/out_tag/out_ovf valid
- out_ready  input  1  downstream accepts result this cycle
- out_product  output  P_W  (in_sum + in_carry) mod 2^64
- out_tag  output  TAG_W  tag of this result
- out_ovf  output  1  resolved sum has any nonzero bit at position >= 64
- err_count  output  8  saturating count of results transferred with out_ovf=1

## Operation
- Stage A (on input transfer, in_valid & in_ready): lo = in_sum[31:0] + in_carry[31:0] (33-bit). Register lo[31:0], c32 = lo[32], in_sum[64:32], in_carry[64:32], in_tag; set a_valid.
- Stage B (on A→B advance): hi = sum_hi + carry_hi + c32 (33-bit operands, 34-bit result). Register out_product = {hi[31:0], lo[31:0]}, out_ovf = |hi[33:32], out_tag; set out_valid.
- Advance rules: B loads when a_valid & (!out_valid | out_ready). A loads when in_valid & in_ready. in_ready = rst & (!a_valid | !out_valid | out_ready).
- When A empties with no new input, a_valid clears. When B is transferred out with no new load, out_valid clears.
- Stall: out_valid & !out_ready holds out_product/out_tag/out_ovf stable. A holds if also occupied, and in_ready then drops to 0.
- No operation is dropped or duplicated. Results leave in acceptance order.
- err_count increments on each output transfer (out_valid & out_ready) with out_ovf=1, and saturates at 255.
- Reset (rst low at a clock edge): a_valid, out_valid, out_product, out_tag, out_ovf, err_count and all stage-A data registers become 0. in_ready is 0 while rst is low.
- Reset mid-operation discards all in-flight operations. No result from before reset is ever presented afterwards.

## Timing
- Latency: input transferred at edge N gives out_valid=1 after edge N+1, when B is free.
- Throughput: one result per cycle with out_ready held 1. in_ready stays 1 continuously in that case.
- Capacity: 2 operations (A + B). With out_ready=0, two transfers fill the pipe, and in_ready=0 from the cycle after the second transfer.
- in_ready depends combinationally on out_ready; there is no combinational path from in_valid to in_ready.
- First edge with rst high: in_ready=1, out_valid=0.

## Test plan
- Carry across halves: in_sum=0x0_00000000_FFFFFFFF, in_carry=0x1, tag 3 -> out_product=0x00000001_00000000, out_ovf=0, out_tag=3, out_valid 2 edges after transfer.
- Max product: rows summing to 0xFFFFFFFE_00000001 (sum=0x0_FFFFFFFE_00000000, carry=0x1) -> exact product, ovf=0. Then sum=0x0_FFFFFFFF_FFFFFFFF, carry=0x1 -> product 0, out_ovf=1, err_count 0→1 on transfer.
- Streaming: 16 back-to-back ops with tags 0..15, out_ready=1 -> 16 consecutive out_valid cycles, correct order, in_ready never 0.
- Backpressure: out_ready=0, drive 3 ops -> first two accepted, in_ready=0 after the 2nd, out_product stable. Raise out_ready for 1 cycle -> 1st result transfers, 3rd op accepted the same cycle, order preserved.
- Reset mid-flight: 2 ops in pipe, pull rst low 1 cycle -> next edge out_valid=0, err_count=0, out_product=0. Neither op ever appears after release.
- Saturation: 260 ovf results -> err_count holds at 255.
